// File: rtl/lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator
//   CPU-side initiator for the single-port SoC memory bus. Accepts one
//   load/store at a time, issues a word-aligned bus request, waits for the
//   memory's data_valid (bounded by TIMEOUT) and returns extended load data or
//   a store completion. Sub-word stores run as read-modify-write.
//
// Ports
//   clk, reset                       clock (rising edge), async active-high reset
//   cpu_req_valid/ready              request handshake (ready only when idle)
//   cpu_we, cpu_size, cpu_unsigned   op type, 00 byte / 01 half / 10 word
//   cpu_addr, cpu_wdata              byte address, right-aligned store data
//   cpu_resp_valid                   one-cycle completion pulse
//   cpu_rdata, cpu_err               result / error, held until next response
//   mem_addr, mem_req_valid, mem_we  bus request (strobe is one cycle)
//   mem_wdata, mem_wdata_oe          write data and tri-state drive enable
//   mem_rdata, mem_data_valid        bus read data and completion
// ---------------------------------------------------------------------------

// One byte lane of the read-modify-write merge. Even lanes take the low store
// byte; odd lanes take the high byte of a halfword unless a byte is stored,
// in which case the byte is replicated across all lanes.
module lsu_merge_lane #(
    parameter int LANE = 0
) (
    input  logic        sel,
    input  logic        byte_mode,
    input  logic [15:0] wdata,
    input  logic [7:0]  old_byte,
    output logic [7:0]  merged
);
    logic [7:0] new_byte;

    assign new_byte = (byte_mode || (LANE % 2 == 0)) ? wdata[7:0] : wdata[15:8];
    assign merged   = sel ? new_byte : old_byte;
endmodule

module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wdata_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

    // Captured request; only the low halfword of store data is needed after
    // accept, since word stores load mem_wdata directly.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } req_t;

    state_t           state, state_n;
    req_t             req;
    logic [CNT_W-1:0] cnt;
    logic             ack, bad_req, word_st, timed_out;

    // X/Z on the completion line must not count as an acknowledge.
    assign ack       = (mem_data_valid === 1'b1);
    assign bad_req   = (cpu_size == 2'b11) ||
                       (cpu_size == 2'b01 && cpu_addr[0]) ||
                       (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
    assign word_st   = cpu_we && (cpu_size == 2'b10);
    assign timed_out = (cnt == CNT_MAX);

    // ---------------- read-modify-write merge ----------------
    logic [NUM_LANES-1:0]      lane_en;
    logic [NUM_LANES-1:0][7:0] old_bytes, merged;

    always_comb begin
        lane_en = '1;
        case (req.size)
            2'b00:   lane_en = NUM_LANES'(1) << req.lane;
            2'b01:   lane_en = NUM_LANES'(2'b11) << {req.lane[1], 1'b0};
            default: lane_en = '1;
        endcase
    end

    assign old_bytes = mem_rdata;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lsu_merge_lane #(.LANE(i)) u_lane (
            .sel       (lane_en[i]),
            .byte_mode (req.size == 2'b00),
            .wdata     (req.wdata),
            .old_byte  (old_bytes[i]),
            .merged    (merged[i])
        );
    end

    // ---------------- load extraction ----------------
    logic [DATA_WIDTH-1:0] shifted, load_data;

    // Halfwords are always aligned here, so lane[0]=0 and the byte shift
    // also lines up the half lane.
    assign shifted = mem_rdata >> {req.lane, 3'b000};

    always_comb begin
        load_data = mem_rdata;
        case (req.size)
            2'b00:   load_data = {{(DATA_WIDTH-8){~req.uns & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(DATA_WIDTH-16){~req.uns & shifted[15]}}, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (cpu_req_valid) begin
                if (bad_req)      state_n = RESP;
                else if (word_st) state_n = WR_REQ;
                else              state_n = RD_REQ;
            end
            RD_REQ:  state_n = RD_WAIT;
            WR_REQ:  state_n = WR_WAIT;
            RD_WAIT: if (ack)            state_n = req.we ? WR_REQ : RESP;
                     else if (timed_out) state_n = RESP;
            WR_WAIT: if (ack || timed_out) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign cpu_req_ready  = (state == IDLE);
    assign cpu_resp_valid = (state == RESP);
    assign mem_req_valid  = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we         = (state == WR_REQ) || (state == WR_WAIT);
    assign mem_wdata_oe   = (state == WR_REQ) || (state == WR_WAIT);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req       <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cpu_req_valid) begin
                    req <= '{we: cpu_we, size: cpu_size, uns: cpu_unsigned,
                             lane: cpu_addr[1:0], wdata: cpu_wdata[15:0]};
                    if (bad_req) begin
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b1;
                    end else begin
                        mem_addr <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (word_st) mem_wdata <= cpu_wdata;
                    end
                end
                RD_REQ, WR_REQ: cnt <= '0;
                RD_WAIT: begin
                    if (ack) begin
                        if (req.we) begin
                            mem_wdata <= merged;
                        end else begin
                            cpu_rdata <= load_data;
                            cpu_err   <= 1'b0;
                        end
                    end else if (timed_out) begin
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (ack) begin
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b0;
                    end else if (timed_out) begin
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
CPU-side initiator for the single-port SoC memory bus. It takes one load/store at a time from the execute/LSU stage and issues the bus request: `mem_addr`, `mem_req_valid`, `mem_we`, write data with an output-enable for the shared tri-state Data bus. It waits for the memory's `data_valid`, then returns sign- or zero-extended load data, or a store completion, to the CPU. Sub-word stores run as read-modify-write, because the memory writes whole words only.

Parameters:
ADDR_WIDTH, 32, width of CPU and memory byte addresses
DATA_WIDTH, 32, bus and register data width (fixed 32; byte lanes assume 4 bytes)
TIMEOUT, 15, max cycles to wait for mem_data_valid after a request before flagging an error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  initiator idle, request accepted when valid&&ready
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
cpu_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
cpu_addr  in  ADDR_WIDTH  byte address
cpu_wdata  in  DATA_WIDTH  store data, right-aligned
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_WIDTH  extended load result (0 for stores/errors)
cpu_err  out  1  qualified by cpu_resp_valid: misaligned/illegal/timeout
mem_addr  out  ADDR_WIDTH  word-aligned bus address (cpu_addr & ~3)
mem_req_valid  out  1  one-cycle request strobe
mem_we  out  1  bus write enable, held with mem_addr until ack
mem_wdata  out  DATA_WIDTH  write data toward tri-state bus
mem_wdata_oe  out  1  1=drive Data bus; top level ties bus = oe ? mem_wdata : 'z
mem_rdata  in  DATA_WIDTH  Data bus as seen by initiator, little-endian word
mem_data_valid  in  1  memory completion; only value 1'b1 counts (X/Z = 0)

Behaviour:
- Reset (async, immediate): state IDLE, cpu_req_ready=1, cpu_resp_valid=0, cpu_rdata=0, cpu_err=0, mem_req_valid=0, mem_we=0, mem_wdata_oe=0, mem_addr=0, mem_wdata=0, timeout counter=0. An in-flight transaction is dropped with no response.
- Request capture: all cpu_* fields are registered on acceptance. cpu_req_ready=1 only in IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- Leaving IDLE on accept:
  - Illegal size, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1. No bus activity.
  - Load, or sub-word store -> RD_REQ.
  - Word store -> WR_REQ.
- RD_REQ / WR_REQ (1 cycle):
  - mem_req_valid=1; mem_we=0 in RD_REQ, 1 in WR_REQ.
  - Counter cleared; next state is RD_WAIT / WR_WAIT.
- RD_WAIT / WR_WAIT:
  - mem_req_valid=0; mem_addr and mem_we held.
  - Counter increments each cycle.
  - On mem_data_valid=1: RD_WAIT captures mem_rdata. It then goes to WR_REQ if the op is a sub-word store, else to RESP. WR_WAIT goes to RESP.
  - If the counter reaches TIMEOUT with no ack -> RESP, err=1.
- mem_wdata_oe=1 exactly in WR_REQ and WR_WAIT; 0 elsewhere, so the bus is released for reads.
- Load extraction:
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - Result is sign- or zero-extended to 32 bits.
- RMW merge: the captured word has byte or half lane(s) replaced with cpu_wdata[7:0] or cpu_wdata[15:0]. Other bytes are unchanged.
- RESP (1 cycle): cpu_resp_valid=1 with cpu_rdata/cpu_err valid, then IDLE. cpu_rdata/cpu_err hold until the next RESP.
- Latency (memory acks the cycle after the request), with T0 = accept cycle:
  - Load or word store: mem_req_valid at T1, ack at T2, cpu_resp_valid at T3.
  - Sub-word store: read request T1, ack T2, write request T3, ack T4, response T5.
  - Error: response at T1.
- A stray mem_data_valid in IDLE/RESP/REQ states is ignored. An ack arriving in the same cycle the counter hits TIMEOUT counts as success.
- No back-to-back overlap: a new accept is possible at the cycle after RESP.

Test Plan:
- Mem word 0x8000_00F1 at addr 0x10; load byte addr 0x10 signed -> mem_req_valid T1, mem_addr=0x10, mem_we=0; cpu_resp_valid T3, cpu_rdata=0xFFFF_FFF1, err=0. Unsigned byte at 0x13 -> 0x0000_0080.
- Word store 0xDEAD_BEEF to 0x20 -> mem_we=1, mem_wdata_oe=1 T1-T2, mem_wdata=0xDEAD_BEEF; response T3; oe=0 from T3. A following load of 0x20 returns 0xDEAD_BEEF.
- Mem 0x1122_3344 at 0x30; store half 0xABCD to 0x32 -> read T1, write T3 with mem_wdata=0xABCD_3344, response T5.
- Load word at 0x21 or half at 0x23 -> cpu_resp_valid T1, err=1, mem_req_valid never asserted.
- Memory never acks (mem_data_valid held Z) -> err=1, cpu_resp_valid exactly TIMEOUT+2 cycles after mem_req_valid; ready returns next cycle.
- Assert reset during WR_WAIT -> all outputs at reset values immediately (oe=0 same cycle). No cpu_resp_valid; next request behaves normally.
